imem_loader: RTL and testbench

- Writer side of the instruction-memory interface that the fetch unit reads.
- Receives a framed byte stream (e.g. from the UART receiver) and assembles 32-bit instruction words.
- Writes those words into the program ROM/RAM write port at consecutive word addresses.
- Holds the CPU in reset while a load is in progress, then releases it so fetch restarts from PC 0.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_word_assembler.sv | 44 ++++
 rtl/imem_loader.sv | 213 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and framing constants for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    // Header, data and checksum words all arrive most-significant byte first.
    localparam bit BIG_ENDIAN = 1'b1;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction-memory write port out of the loader
interface imem_loader_if #(
    parameter int ADDR_W = 14
) ();

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/imem_word_assembler.sv
// rtl/imem_word_assembler.sv - shifts accepted bytes into 32-bit words, flagging the last byte of each
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_CNT = 2'(WORD_BYTES - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;

    // word is the completed value including the byte being accepted this cycle.
    always_comb begin
        word       = BIG_ENDIAN ? {shift_q[23:0], byte_data} : {byte_data, shift_q[31:8]};
        word_valid = byte_valid && (cnt_q == LAST_CNT);
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader into instruction memory; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum word
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int MAX_WORDS = 16384
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    imem_loader_if.master   bus,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [ADDR_W:0] word_count
);

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [31:0]       MAX_N    = 32'(MAX_WORDS);

    state_e            state_q, state_d;
    logic              rx_ready_q, rx_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W:0]   n_q, n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
`endif

    logic        rx_fire;
    logic        asm_clear;
    logic        word_valid;
    logic [31:0] word;
    logic        last_word;

    assign rx_fire   = bus.rx_valid && rx_ready_q;
    assign last_word = (word_count_q + CNT_ONE) == n_q;

    imem_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (rx_fire),
        .byte_data  (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // All outputs are registered: each branch sets the values seen in the next state.
    always_comb begin
        state_d      = state_q;
        rx_ready_d   = rx_ready_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cpu_hold_d   = cpu_hold_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        word_count_d = word_count_q;
        n_d          = n_q;
        asm_clear    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        // Address stays on the last written word so it never passes MAX_WORDS-1.
        if (wr_en_q) begin
            word_count_d = word_count_q + CNT_ONE;
            if (!last_word) wr_addr_d = wr_addr_q + ADDR_ONE;
        end

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_d      = ST_HDR;
                    rx_ready_d   = 1'b1;
                    cpu_hold_d   = 1'b1;
                    busy_d       = 1'b1;
                    err_d        = 1'b0;
                    word_count_d = '0;
                    wr_addr_d    = '0;
                    asm_clear    = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d        = '0;
`endif
                end
            end
            ST_HDR: begin
                if (word_valid) begin
                    n_d = word[ADDR_W:0];
                    if (word > MAX_N) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        busy_d     = 1'b0;
                        rx_ready_d = 1'b0;
                    end else if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d    = ST_CSUM;
`else
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                        busy_d     = 1'b0;
                        rx_ready_d = 1'b0;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    wr_en_d    = 1'b1;
                    wr_data_d  = word;
                    rx_ready_d = !last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + word;
`endif
                end
                if (wr_en_q && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d    = ST_CSUM;
                    rx_ready_d = 1'b1;
`else
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                    busy_d     = 1'b0;
                    rx_ready_d = 1'b0;
`endif
                end
            end
            ST_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (word_valid) begin
                    rx_ready_d = 1'b0;
                    busy_d     = 1'b0;
                    if (word == sum_q) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rx_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
            n_q          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            word_count_q <= word_count_d;
            n_q          <= n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign word_count   = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized frame loads checked against a frame-level reference model
module tb_imem_loader;

    localparam int ADDR_W    = 14;
    localparam int MAX_WORDS = 16384;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            cpu_hold;
    logic            busy;
    logic            done;
    logic            err;
    logic [ADDR_W:0] word_count;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] frame_words[$];

    // Observed write port and done pulses, appended only by the monitor.
    logic [ADDR_W-1:0] wr_addr_log[$];
    logic [31:0]       wr_data_log[$];
    int                done_cnt = 0;
    logic              done_hold;
    logic              done_busy;
    logic [ADDR_W:0]   done_wc;

    always @(negedge clk) begin
        if (bus.wr_en) begin
            wr_addr_log.push_back(bus.wr_addr);
            wr_data_log.push_back(bus.wr_data);
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_hold <= cpu_hold;
            done_busy <= busy;
            done_wc   <= word_count;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        int  idle;
        int  tries;
        bit  acc;
        idle = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        bus.rx_valid = 1'b0;
        repeat (idle) tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 100) begin
            acc = bus.rx_ready;
            tick();
            tries++;
        end
        if (!acc) check_val("rx_accept_timeout", 64'd0, 64'd1);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_mode);
        send_byte(w[31:24], gap_mode);
        send_byte(w[23:16], gap_mode);
        send_byte(w[15:8],  gap_mode);
        send_byte(w[7:0],   gap_mode);
    endtask

    // Reference: a legal header writes frame_words[i] at address i and ends in one done pulse
    // with word_count = N; an oversize header or wrong checksum ends in err with cpu_hold held.
    task automatic run_frame(input logic [31:0] n, input int gap_mode, input bit bad_csum,
                             input bit mid_start);
        int          wr_base;
        int          done_base;
        int          waited;
        int          n_exp;
        bit          hdr_bad;
        bit          exp_err;
        logic [31:0] sum;
        wr_base   = wr_addr_log.size();
        done_base = done_cnt;
        hdr_bad   = (n > 32'(MAX_WORDS));
        n_exp     = hdr_bad ? 0 : int'(n);
        exp_err   = hdr_bad || (CSUM_ON && bad_csum);

        pulse_start();
        check_val("start_cpu_hold", cpu_hold, 1);
        check_val("start_busy", busy, 1);
        check_val("start_err", err, 0);
        check_val("start_word_count", word_count, 0);

        send_word(n, gap_mode);
        if (mid_start) pulse_start();
        sum = 32'd0;
        if (!hdr_bad) begin
            for (int i = 0; i < n_exp; i++) begin
                send_word(frame_words[i], gap_mode);
                sum += frame_words[i];
            end
            if (CSUM_ON) send_word(bad_csum ? sum + 32'd1 : sum, gap_mode);
        end

        waited = 0;
        while (done_cnt == done_base && !err && waited < 20) begin
            tick();
            waited++;
        end
        repeat (3) tick();

        check_val("write_count", 64'(wr_addr_log.size() - wr_base), 64'(n_exp));
        for (int i = 0; i < n_exp && (wr_base + i) < wr_addr_log.size(); i++) begin
            check_val("wr_addr", wr_addr_log[wr_base + i], 64'(i));
            check_val("wr_data", wr_data_log[wr_base + i], frame_words[i]);
        end
        if (exp_err) begin
            check_val("err_level", err, 1);
            check_val("err_cpu_hold", cpu_hold, 1);
            check_val("err_busy", busy, 0);
            check_val("err_rx_ready", bus.rx_ready, 0);
            check_val("err_no_done", 64'(done_cnt - done_base), 0);
        end else begin
            check_val("done_pulses", 64'(done_cnt - done_base), 1);
            check_val("done_cpu_hold", done_hold, 0);
            check_val("done_busy", done_busy, 0);
            check_val("done_word_count", done_wc, 64'(n_exp));
            check_val("end_err", err, 0);
            check_val("end_cpu_hold", cpu_hold, 0);
            check_val("end_rx_ready", bus.rx_ready, 0);
            check_val("end_word_count", word_count, 64'(n_exp));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rx_ready"}, bus.rx_ready, 0);
        check_val({tag, "_wr_en"}, bus.wr_en, 0);
        check_val({tag, "_wr_addr"}, bus.wr_addr, 0);
        check_val({tag, "_wr_data"}, bus.wr_data, 0);
        check_val({tag, "_cpu_hold"}, cpu_hold, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_err"}, err, 0);
        check_val({tag, "_word_count"}, word_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset        = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        frame_words = {32'h20080005, 32'hAC080000};
        run_frame(32'd2, 0, 1'b0, 1'b0);

        frame_words = {};
        run_frame(32'd0, 0, 1'b0, 1'b0);

        run_frame(32'd16385, 0, 1'b0, 1'b0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5A;
        repeat (3) tick();
        check_val("err_holds_rx_ready", bus.rx_ready, 0);
        bus.rx_valid = 1'b0;
        frame_words = {32'hDEADBEEF};
        run_frame(32'd1, 0, 1'b0, 1'b0);

        frame_words = {32'h0123ABCD};
        run_frame(32'd1, 1, 1'b0, 1'b0);

        frame_words = {32'h00000001, 32'h00000002, 32'h00000003};
        run_frame(32'd3, 2, 1'b0, 1'b1);

        pulse_start();
        send_word(32'd2, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset = 1'b1;
        tick();
        check_reset_outputs("midreset");
        reset = 1'b0;
        tick();
        frame_words = {32'hCAFEF00D};
        run_frame(32'd1, 1, 1'b0, 1'b0);

        frame_words = {32'h00000001, 32'h00000002};
        run_frame(32'd2, 0, 1'b0, 1'b0);
        run_frame(32'd2, 0, 1'b1, 1'b0);

        for (int f = 0; f < 8; f++) begin
            n = int'($urandom_range(1, 6));
            frame_words = {};
            for (int i = 0; i < n; i++) frame_words.push_back($urandom);
            run_frame(32'(n), f % 3, 1'($urandom_range(0, 1)), 1'(f == 5));
        end

        run_frame(32'(MAX_WORDS) + 32'($urandom_range(1, 1000)), 2, 1'b0, 1'b0);
        run_frame(32'hFFFFFFFF, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
